collision_event_handler: RTL and testbench
==========================================

# collision_event_handler

Consumes the raw per-pixel collision flags from the game controller (shot/tower, shot/enemy, tower/enemy) and turns them into clean once-per-frame game events: shot-removal pulses, enemy-hit pulse, tower-hit pulse, a BCD score and a tower-lives counter with an invulnerability window and game-over state. It sits between the collision detector and the object/score/display blocks. All outputs are single-cycle pulses or registered state, so downstream blocks never see pixel-rate collision bursts.

## Interface
- TOWER_LIVES, 3: lives loaded on reset/restart (1..7).
- INVULN_FRAMES, 30: frames of tower invulnerability after a hit (1..63).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at the start of every frame.
- restart  in  1  one-cycle request to start a new game.
- ShotBoxCollision  in  3  per-shot-slot collision with tower/box (bit i = shot i).
- ShotEnemyCollision  in  3  per-shot-slot collision with enemy.
- TowerEnemyHUCollision  in  1  enemy overlapping tower.
- shot_remove  out  3  one-cycle pulse per slot: retire shot i.
- enemy_hit  out  1  one-cycle pulse: enemy destroyed.
- tower_hit  out  1  one-cycle pulse: tower lost a life.
- score  out  12  3-digit BCD score, {hundreds, tens, units}.
- lives  out  3  remaining tower lives.
- game_over  out  1  level, high in OVER state.

## Operation
- Per-frame flags: shot_done[2:0], enemy_done, tower_done. Cleared when startOfFrame=1. An event fires only when its flag is clear, and firing sets the flag, so each event fires at most once per frame.
- If startOfFrame and a collision occur in the same cycle, the clear is applied first and the collision counts as the first event of the new frame.
- Shot slot i fires when ShotBoxCollision[i] or ShotEnemyCollision[i] is high and shot_done[i]=0. Firing pulses shot_remove[i] and sets shot_done[i]. Slots are independent, so several bits may pulse in the same cycle.
- Enemy event fires when any ShotEnemyCollision bit is high and enemy_done=0. It pulses enemy_hit and adds 1 to score.
- Score is BCD with carry units→tens→hundreds and saturates at 999.
- FSM states: RUN, INVULN, OVER.
  - RUN: TowerEnemyHUCollision with tower_done=0 pulses tower_hit, decrements lives and sets tower_done. If lives was 1, go to OVER; otherwise go to INVULN and load frame counter = INVULN_FRAMES.
  - INVULN: tower collisions are ignored (no pulse, no decrement). Each startOfFrame decrements the counter. Return to RUN on the startOfFrame that brings it to 0. Shot and enemy events still operate.
  - OVER: game_over=1. All pulse outputs are forced 0. score and lives are frozen.
  - restart (any state): go to RUN, lives=TOWER_LIVES, score=0, all flags cleared, no pulse in that cycle. restart takes precedence over every collision in the same cycle.
- reset: same as restart. Reset values are shot_remove=0, enemy_hit=0, tower_hit=0, score=12'h000, lives=TOWER_LIVES, game_over=0, state RUN, counter=0.

## Timing
- All outputs are registered.
- A collision sampled at rising edge N produces its pulse during cycle N+1, one cycle wide.
- score and lives update on the same edge that raises enemy_hit/tower_hit.
- game_over rises on the same edge as the final tower_hit pulse.
- A collision held high for many cycles within one frame yields exactly one pulse.
- Invulnerability length: exactly INVULN_FRAMES startOfFrame pulses after the hit. The startOfFrame that ends INVULN also clears tower_done, so a tower collision in that same cycle fires.
- Reset or restart asserted mid-frame or mid-INVULN takes effect at the next edge.

## Test plan
- ShotEnemyCollision=3'b010 held 200 cycles within one frame -> shot_remove=3'b010 and enemy_hit=1 for exactly one cycle; score=12'h001. Repeated next frame -> score=12'h002.
- ShotBoxCollision=3'b101 and ShotEnemyCollision=3'b000 in the same cycle -> shot_remove=3'b101 once; no enemy_hit; score unchanged.
- Score preset to 12'h099 via 99 framed hits, then one more hit -> 12'h100. From 999, a further hit -> stays 12'h999 while enemy_hit still pulses.
- TowerEnemyHUCollision held across 40 frames (INVULN_FRAMES=30) -> tower_hit in frame 0 and frame 30 only; lives 3→2→1.
- Third tower hit -> lives=0 and game_over=1 on the same edge. Further collisions produce no pulses. restart -> lives=3, score=0, game_over=0 next cycle.
- startOfFrame coincident with ShotEnemyCollision after an earlier hit in the previous frame -> a new enemy_hit fires. reset asserted during INVULN -> state RUN with all outputs at reset values.

Source files
------------

// File: rtl/collision_event_handler_if.sv
// Collision-event bundle: raw per-pixel collision flags in,
// per-frame game events and score/lives state out.
interface collision_event_handler_if;
  logic        startOfFrame;
  logic        restart;
  logic [2:0]  ShotBoxCollision;
  logic [2:0]  ShotEnemyCollision;
  logic        TowerEnemyHUCollision;
  logic [2:0]  shot_remove;
  logic        enemy_hit;
  logic        tower_hit;
  logic [11:0] score;
  logic [2:0]  lives;
  logic        game_over;

  modport master (
    output startOfFrame, restart,
    output ShotBoxCollision, ShotEnemyCollision,
    output TowerEnemyHUCollision,
    input  shot_remove, enemy_hit, tower_hit,
    input  score, lives, game_over
  );

  modport slave (
    input  startOfFrame, restart,
    input  ShotBoxCollision, ShotEnemyCollision,
    input  TowerEnemyHUCollision,
    output shot_remove, enemy_hit, tower_hit,
    output score, lives, game_over
  );
endinterface

// File: rtl/collision_event_handler.sv
// Turns pixel-rate collision flags into once-per-frame events,
// BCD score, tower lives with invulnerability, and game-over.
module collision_event_handler #(
  parameter int TOWER_LIVES   = 3,
  parameter int INVULN_FRAMES = 30
) (
  input logic                      clk,
  input logic                      reset,
  collision_event_handler_if.slave bus
);
  typedef enum logic [1:0] {
    RUN, INVULN, OVER
  } state_t;

  state_t      r_state, w_state_n;
  logic [5:0]  r_cnt, w_cnt_n;
  logic [2:0]  r_lives, w_lives_n;
  logic [11:0] r_score, w_score_inc;
  logic [2:0]  r_shot_done;
  logic        r_enemy_done, r_tower_done;
  logic [2:0]  r_shot_remove;
  logic        r_enemy_hit, r_tower_hit;
  logic        r_game_over;
  logic [2:0]  w_shot_done, w_shot_fire;
  logic        w_enemy_done, w_tower_done;
  logic        w_enemy_fire, w_tower_fire;
  logic        w_active, w_tower_ok;

  // Frame start clears flags before this cycle's collisions are judged
  assign w_shot_done  = bus.startOfFrame ? 3'b000 : r_shot_done;
  assign w_enemy_done = bus.startOfFrame ? 1'b0 : r_enemy_done;
  assign w_tower_done = bus.startOfFrame ? 1'b0 : r_tower_done;

  assign w_active = (r_state != OVER) && !bus.restart;

  assign w_shot_fire = {3{w_active}}
                     & (bus.ShotBoxCollision | bus.ShotEnemyCollision)
                     & ~w_shot_done;

  assign w_enemy_fire = w_active
                      && (|bus.ShotEnemyCollision)
                      && !w_enemy_done;

  // Last frame of invulnerability re-arms the tower in the same cycle
  assign w_tower_ok = (r_state == RUN)
                   || (r_state == INVULN && bus.startOfFrame
                       && r_cnt == 6'd1);

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_lives_n    = r_lives;
    w_tower_fire = 1'b0;
    unique case (r_state)
      RUN: ;
      INVULN: begin
        if (bus.startOfFrame) begin
          w_cnt_n = r_cnt - 6'd1;
          if (r_cnt == 6'd1) w_state_n = RUN;
        end
      end
      OVER: ;
      default: w_state_n = RUN;
    endcase
    if (w_tower_ok && bus.TowerEnemyHUCollision && !w_tower_done) begin
      w_tower_fire = 1'b1;
      w_lives_n    = r_lives - 3'd1;
      if (r_lives == 3'd1) begin
        w_state_n = OVER;
        w_cnt_n   = 6'd0;
      end else begin
        w_state_n = INVULN;
        w_cnt_n   = 6'(INVULN_FRAMES);
      end
    end
    if (bus.restart) begin
      w_state_n    = RUN;
      w_cnt_n      = 6'd0;
      w_lives_n    = 3'(TOWER_LIVES);
      w_tower_fire = 1'b0;
    end
  end

  // BCD increment with saturation at 999
  always_comb begin
    w_score_inc = r_score;
    if (r_score != 12'h999) begin
      if (r_score[3:0] != 4'd9) begin
        w_score_inc[3:0] = r_score[3:0] + 4'd1;
      end else begin
        w_score_inc[3:0] = 4'd0;
        if (r_score[7:4] != 4'd9) begin
          w_score_inc[7:4] = r_score[7:4] + 4'd1;
        end else begin
          w_score_inc[7:4]  = 4'd0;
          w_score_inc[11:8] = r_score[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.restart) begin
      r_cnt         <= 6'd0;
      r_lives       <= 3'(TOWER_LIVES);
      r_score       <= 12'h000;
      r_shot_done   <= 3'b000;
      r_enemy_done  <= 1'b0;
      r_tower_done  <= 1'b0;
      r_shot_remove <= 3'b000;
      r_enemy_hit   <= 1'b0;
      r_tower_hit   <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_n;
      r_lives       <= w_lives_n;
      r_shot_done   <= w_shot_done | w_shot_fire;
      r_enemy_done  <= w_enemy_done | w_enemy_fire;
      r_tower_done  <= w_tower_done | w_tower_fire;
      r_shot_remove <= w_shot_fire;
      r_enemy_hit   <= w_enemy_fire;
      r_tower_hit   <= w_tower_fire;
      r_game_over   <= (w_state_n == OVER);
      if (w_enemy_fire) r_score <= w_score_inc;
    end
  end

  assign bus.shot_remove = r_shot_remove;
  assign bus.enemy_hit   = r_enemy_hit;
  assign bus.tower_hit   = r_tower_hit;
  assign bus.score       = r_score;
  assign bus.lives       = r_lives;
  assign bus.game_over   = r_game_over;
endmodule

// File: tb/tb_collision_event_handler.sv
// Directed + random bench for collision_event_handler against
// a frame-level event model.
module tb_collision_event_handler;
  localparam int TL = 3;
  localparam int IF = 30;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  collision_event_handler_if bus();

  collision_event_handler #(
    .TOWER_LIVES  (TL),
    .INVULN_FRAMES(IF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int   m_lives, m_score, m_inv;
  bit   m_over;
  bit   m_sd [3];
  bit   m_ed, m_td;
  logic [2:0] e_sr;
  logic e_eh, e_th;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model(input bit sof, input bit rs, input logic [2:0] sb,
                       input logic [2:0] se, input bit te);
    e_sr = 3'b000; e_eh = 1'b0; e_th = 1'b0;
    if (rs) begin
      m_lives = TL; m_score = 0; m_over = 0; m_inv = 0;
      for (int i = 0; i < 3; i++) m_sd[i] = 0;
      m_ed = 0; m_td = 0;
      return;
    end
    if (sof) begin
      for (int i = 0; i < 3; i++) m_sd[i] = 0;
      m_ed = 0; m_td = 0;
    end
    if (m_over) return;
    for (int i = 0; i < 3; i++)
      if ((sb[i] || se[i]) && !m_sd[i]) begin
        e_sr[i] = 1'b1; m_sd[i] = 1;
      end
    if (se != 0 && !m_ed) begin
      e_eh = 1'b1; m_ed = 1;
      if (m_score < 999) m_score++;
    end
    if (m_inv > 0 && sof) m_inv--;
    if (m_inv == 0 && te && !m_td) begin
      e_th = 1'b1; m_td = 1;
      m_lives--;
      if (m_lives == 0) m_over = 1;
      else m_inv = IF;
    end
  endtask

  task automatic cyc(input bit sof, input bit rs, input bit rst,
                     input logic [2:0] sb, input logic [2:0] se,
                     input bit te);
    reset                     = rst;
    bus.startOfFrame          = sof;
    bus.restart               = rs;
    bus.ShotBoxCollision      = sb;
    bus.ShotEnemyCollision    = se;
    bus.TowerEnemyHUCollision = te;
    @(posedge clk);
    model(sof, rs | rst, sb, se, te);
    #1;
    chk("shot_remove", bus.shot_remove, e_sr);
    chk("enemy_hit", bus.enemy_hit, e_eh);
    chk("tower_hit", bus.tower_hit, e_th);
    chk("score", bus.score, bcd(m_score));
    chk("lives", bus.lives, m_lives);
    chk("game_over", bus.game_over, m_over);
  endtask

  initial begin
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("rst_score", bus.score, 12'h000);
    chk("rst_lives", bus.lives, 3);

    cyc(1, 0, 0, 0, 3'b010, 0);
    repeat (199) cyc(0, 0, 0, 0, 3'b010, 0);
    chk("held_score", bus.score, 12'h001);
    cyc(1, 0, 0, 0, 3'b010, 0);
    repeat (20) cyc(0, 0, 0, 0, 3'b010, 0);
    chk("two_frames", bus.score, 12'h002);

    cyc(1, 0, 0, 3'b101, 3'b000, 0);
    chk("box_only", bus.shot_remove, 3'b101);
    repeat (5) cyc(0, 0, 0, 3'b101, 3'b000, 0);

    for (int f = 0; f < 998; f++) begin
      cyc(1, 0, 0, 0, 3'b001, 0);
      cyc(0, 0, 0, 0, 3'b001, 0);
    end
    chk("score_sat", bus.score, 12'h999);

    for (int f = 0; f < 65; f++) begin
      cyc(1, 0, 0, 0, 0, 1);
      repeat (3) cyc(0, 0, 0, 0, 0, 1);
    end
    chk("over_level", bus.game_over, 1'b1);
    chk("over_lives", bus.lives, 3'd0);
    cyc(1, 0, 0, 3'b111, 3'b111, 1);
    cyc(0, 0, 0, 3'b111, 3'b111, 1);
    cyc(0, 1, 0, 3'b111, 3'b111, 1);
    chk("restart_lives", bus.lives, 3'd3);
    chk("restart_score", bus.score, 12'h000);
    chk("restart_over", bus.game_over, 1'b0);

    cyc(1, 0, 0, 0, 3'b100, 0);
    cyc(0, 0, 0, 0, 3'b000, 0);
    cyc(1, 0, 0, 0, 3'b100, 0);
    chk("sof_coincident", bus.enemy_hit, 1'b1);

    cyc(1, 0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    chk("inv_reset_lives", bus.lives, 3'd3);
    cyc(0, 0, 0, 0, 0, 1);
    chk("post_reset_hit", bus.tower_hit, 1'b1);

    for (int c = 0; c < 5000; c++) begin
      cyc(($urandom_range(7) == 0),
          ($urandom_range(150) == 0),
          ($urandom_range(400) == 0),
          ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000,
          ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000,
          ($urandom_range(5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
